// File: rtl/quad_vel_meter.sv
// Quadrature encoder decoder: 2-flop sync, per-channel glitch filter, 4x decode,
// modulo-CPR position, edge counter, windowed signed velocity with saturation.
// Latency: input change -> pos in FILT_LEN+3 clk edges; no backpressure (free-running).
module quad_vel_meter #(
  parameter int POS_W         = 16,
  parameter int CPR           = 1497,
  parameter int VEL_W         = 16,
  parameter int SAMPLE_CYCLES = 131072,
  parameter int FILT_LEN      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    quad_a,
  input  logic                    quad_b,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic [POS_W-1:0]        pos,
  output logic [31:0]             edge_count,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    err
);

  localparam int CW   = $clog2(FILT_LEN + 1);
  localparam int TW   = $clog2(SAMPLE_CYCLES);
  localparam int VMAX = 2**(VEL_W-1) - 1;
  localparam int VMIN = -(2**(VEL_W-1));
  localparam int AMAX = 2**VEL_W - 1;
  localparam int AMIN = -(2**VEL_W);
  localparam logic [POS_W-1:0] LAST = POS_W'(CPR - 1);

  // Bit 1 = channel A, bit 0 = channel B throughout.
  logic [1:0]          s1, s2;
  logic [1:0]          filt, prev;
  logic [CW-1:0]       cnt [2];
  logic [1:0]          init_cnt;
  logic                active, fwd, rev, bad;
  logic [1:0]          cur_bin, prev_bin, delta;
  logic [TW-1:0]       timer;
  logic                term;
  logic signed [VEL_W:0]   acc, acc_nxt;
  logic signed [VEL_W+1:0] step_v, sum;
  logic signed [VEL_W-1:0] vel_sat;

  // Two-flop synchroniser for the asynchronous encoder channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {quad_a, quad_b};
      s2 <= s1;
    end
  end

  // Filter plus previous-value register. For the first three cycles after reset
  // both track the synchronised inputs directly so reset release never yields a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= 2'd0;
      filt     <= 2'b00;
      prev     <= 2'b00;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else if (init_cnt != 2'd3) begin
      init_cnt <= init_cnt + 2'd1;
      filt     <= s2;
      prev     <= s2;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == CW'(FILT_LEN - 1)) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Gray-to-binary phase difference: +1 forward, -1 reverse, 2 means both channels moved.
  always_comb begin
    active   = (init_cnt == 2'd3);
    cur_bin  = {filt[1], filt[1] ^ filt[0]};
    prev_bin = {prev[1], prev[1] ^ prev[0]};
    delta    = cur_bin - prev_bin;
    fwd      = active && (delta == 2'd1);
    rev      = active && (delta == 2'd3);
    bad      = active && (delta == 2'd2);
  end

  // Position, edge counter, direction and sticky error; clear beats a same-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos        <= '0;
      edge_count <= '0;
      dir        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (pos_clr)  pos <= '0;
      else if (fwd) pos <= (pos == LAST) ? '0 : pos + 1'b1;
      else if (rev) pos <= (pos == '0) ? LAST : pos - 1'b1;
      if (fwd || rev) begin
        edge_count <= edge_count + 32'd1;
        dir        <= fwd;
      end
      if (bad)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Accumulator update including the current step, saturated for both the
  // accumulator itself and the narrower velocity output.
  always_comb begin
    step_v = '0;
    if (fwd)      step_v = (VEL_W+2)'(1);
    else if (rev) step_v = {(VEL_W+2){1'b1}};
    sum = $signed({acc[VEL_W], acc}) + step_v;
    if (sum > AMAX)      acc_nxt = (VEL_W+1)'(AMAX);
    else if (sum < AMIN) acc_nxt = (VEL_W+1)'(AMIN);
    else                 acc_nxt = sum[VEL_W:0];
    if (sum > VMAX)      vel_sat = VEL_W'(VMAX);
    else if (sum < VMIN) vel_sat = VEL_W'(VMIN);
    else                 vel_sat = sum[VEL_W-1:0];
  end

  assign term = (timer == TW'(SAMPLE_CYCLES - 1));

  // Free-running window timer; pos_clr deliberately does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       timer <= '0;
    else if (term) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  // Window close publishes the accumulated steps even if pos_clr is also active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= term;
      if (term) velocity <= vel_sat;
      if (term || pos_clr) acc <= '0;
      else                 acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_quad_vel_meter.sv
// Bench for quad_vel_meter: instance A (FILT_LEN=3, window 100) for decode and
// velocity, instance B (FILT_LEN=1, window 256) for saturation. Reference model
// tracks position/count arithmetically and velocity from a list of timed steps.
module tb_quad_vel_meter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_a = 1'b0, a_b = 1'b0, a_pclr = 1'b0, a_eclr = 1'b0;
  logic b_a = 1'b0, b_b = 1'b0;
  logic [15:0]       a_pos, b_pos;
  logic [31:0]       a_ec, b_ec;
  logic signed [7:0] a_vel, b_vel;
  logic a_vv, a_dir, a_err, b_vv, b_dir, b_err;

  quad_vel_meter #(.POS_W(16), .CPR(8), .VEL_W(8), .SAMPLE_CYCLES(100), .FILT_LEN(3)) dut_a (
    .clk(clk), .rst(rst), .quad_a(a_a), .quad_b(a_b), .pos_clr(a_pclr), .err_clr(a_eclr),
    .pos(a_pos), .edge_count(a_ec), .velocity(a_vel), .vel_valid(a_vv), .dir(a_dir), .err(a_err));

  quad_vel_meter #(.POS_W(16), .CPR(8), .VEL_W(8), .SAMPLE_CYCLES(256), .FILT_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .quad_a(b_a), .quad_b(b_b), .pos_clr(1'b0), .err_clr(1'b0),
    .pos(b_pos), .edge_count(b_ec), .velocity(b_vel), .vel_valid(b_vv), .dir(b_dir), .err(b_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int ph = 0, bph = 0;
  int m_pos = 0, m_ec = 0, m_dir = 0, rel = 0;
  int q_e[$], q_d[$];
  bit mon_en = 1'b0;
  int mon_sum, mon_exp_vv;

  function automatic logic [1:0] gray(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Velocity monitor: pulse must land exactly on window ends; value = sum of steps in the window.
  always begin
    @(posedge clk);
    #2;
    if (mon_en && !rst) begin
      mon_exp_vv = ((cyc > rel) && ((cyc - rel) % 100 == 0)) ? 1 : 0;
      vectors++;
      if (a_vv !== mon_exp_vv[0]) begin
        miscompares++;
        $display("FAIL mon_vel_valid cyc=%0d got %b exp %0d", cyc, a_vv, mon_exp_vv);
      end
      if (mon_exp_vv == 1) begin
        mon_sum = 0;
        foreach (q_e[i]) if (q_e[i] > cyc - 100 && q_e[i] <= cyc) mon_sum += q_d[i];
        if (mon_sum > 127) mon_sum = 127;
        if (mon_sum < -128) mon_sum = -128;
        vectors++;
        if (a_vel !== 8'(mon_sum)) begin
          miscompares++;
          $display("FAIL mon_velocity cyc=%0d got %0d exp %0d", cyc, a_vel, mon_sum);
        end
        for (int i = q_e.size() - 1; i >= 0; i--)
          if (q_e[i] <= cyc) begin q_e.delete(i); q_d.delete(i); end
      end
    end
  end

  task automatic drive_step(input bit fwd);
    @(negedge clk);
    ph = fwd ? (ph + 1) % 4 : (ph + 3) % 4;
    {a_a, a_b} = gray(ph);
    m_pos = fwd ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
    m_ec++;
    m_dir = fwd;
    q_e.push_back(cyc + 6);
    q_d.push_back(fwd ? 1 : -1);
  endtask

  task automatic model_reset_release;
    rel = cyc;
    q_e.delete();
    q_d.delete();
    m_pos = 0; m_ec = 0; m_dir = 0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    while ((cyc + 1 - rel) % 100 == 0) @(negedge clk);
    a_pclr = 1'b1;
    for (int i = q_e.size() - 1; i >= 0; i--)
      if (q_e[i] <= cyc + 1) begin q_e.delete(i); q_d.delete(i); end
    m_pos = 0;
    @(negedge clk);
    a_pclr = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (a_pos !== 16'd0) begin miscompares++; $display("FAIL reset_pos got %0d exp 0", a_pos); end
    vectors++; if (a_ec !== 32'd0) begin miscompares++; $display("FAIL reset_ec got %0d exp 0", a_ec); end
    vectors++; if (a_vel !== 8'sd0) begin miscompares++; $display("FAIL reset_vel got %0d exp 0", a_vel); end
    vectors++; if (a_vv !== 1'b0) begin miscompares++; $display("FAIL reset_vv got %b exp 0", a_vv); end
    vectors++; if (a_dir !== 1'b0) begin miscompares++; $display("FAIL reset_dir got %b exp 0", a_dir); end
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", a_err); end
    rst = 1'b0;
    model_reset_release();
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_forward;
    int old;
    for (int i = 0; i < 10; i++) begin
      old = m_pos;
      drive_step(1'b1);
      repeat (5) @(negedge clk);
      vectors++; if (a_pos !== 16'(old)) begin miscompares++; $display("FAIL fwd_early step=%0d got %0d exp %0d", i, a_pos, old); end
      @(negedge clk);
      vectors++; if (a_pos !== 16'(m_pos)) begin miscompares++; $display("FAIL fwd_pos step=%0d got %0d exp %0d", i, a_pos, m_pos); end
      repeat (14) @(negedge clk);
    end
    vectors++; if (a_pos !== 16'd2) begin miscompares++; $display("FAIL fwd_final_pos got %0d exp 2", a_pos); end
    vectors++; if (a_ec !== 32'd10) begin miscompares++; $display("FAIL fwd_ec got %0d exp 10", a_ec); end
    vectors++; if (a_dir !== 1'b1) begin miscompares++; $display("FAIL fwd_dir got %b exp 1", a_dir); end
  endtask

  task automatic test_reverse;
    pulse_clr();
    vectors++; if (a_pos !== 16'd0) begin miscompares++; $display("FAIL rev_clr got %0d exp 0", a_pos); end
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0);
      repeat (6) @(negedge clk);
      vectors++; if (a_pos !== 16'(7 - i)) begin miscompares++; $display("FAIL rev_pos step=%0d got %0d exp %0d", i, a_pos, 7 - i); end
      repeat (4) @(negedge clk);
    end
    vectors++; if (a_ec !== 32'(m_ec)) begin miscompares++; $display("FAIL rev_ec got %0d exp %0d", a_ec, m_ec); end
    vectors++; if (a_dir !== 1'b0) begin miscompares++; $display("FAIL rev_dir got %b exp 0", a_dir); end
  endtask

  task automatic test_glitch;
    @(negedge clk); a_a = ~a_a;
    repeat (2) @(negedge clk); a_a = ~a_a;
    repeat (10) @(negedge clk);
    vectors++; if (a_pos !== 16'(m_pos)) begin miscompares++; $display("FAIL glitch_pos got %0d exp %0d", a_pos, m_pos); end
    vectors++; if (a_ec !== 32'(m_ec)) begin miscompares++; $display("FAIL glitch_ec got %0d exp %0d", a_ec, m_ec); end
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL glitch_err got %b exp 0", a_err); end
  endtask

  task automatic test_err;
    @(negedge clk); ph = (ph + 2) % 4; {a_a, a_b} = gray(ph);
    repeat (5) @(negedge clk);
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL err_early got %b exp 0", a_err); end
    @(negedge clk);
    vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b exp 1", a_err); end
    vectors++; if (a_pos !== 16'(m_pos)) begin miscompares++; $display("FAIL err_pos got %0d exp %0d", a_pos, m_pos); end
    vectors++; if (a_ec !== 32'(m_ec)) begin miscompares++; $display("FAIL err_ec got %0d exp %0d", a_ec, m_ec); end
    a_eclr = 1'b1; @(negedge clk); a_eclr = 1'b0;
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL err_clr got %b exp 0", a_err); end
    // Illegal transition and err_clr landing on the same edge: set wins.
    @(negedge clk); ph = (ph + 2) % 4; {a_a, a_b} = gray(ph);
    repeat (5) @(negedge clk);
    a_eclr = 1'b1; @(negedge clk); a_eclr = 1'b0;
    vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL err_set_wins got %b exp 1", a_err); end
    a_eclr = 1'b1; @(negedge clk); a_eclr = 1'b0;
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL err_clr2 got %b exp 0", a_err); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clr_priority;
    @(negedge clk);
    while ((cyc + 7 - rel) % 100 == 0) @(negedge clk);
    drive_step(1'b1);
    repeat (5) @(negedge clk);
    a_pclr = 1'b1;
    for (int i = q_e.size() - 1; i >= 0; i--)
      if (q_e[i] <= cyc + 1) begin q_e.delete(i); q_d.delete(i); end
    m_pos = 0;
    @(negedge clk); a_pclr = 1'b0;
    vectors++; if (a_pos !== 16'd0) begin miscompares++; $display("FAIL clrpri_pos got %0d exp 0", a_pos); end
    vectors++; if (a_ec !== 32'(m_ec)) begin miscompares++; $display("FAIL clrpri_ec got %0d exp %0d", a_ec, m_ec); end
    vectors++; if (a_dir !== 1'b1) begin miscompares++; $display("FAIL clrpri_dir got %b exp 1", a_dir); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clr_terminal;
    while ((cyc - rel) % 100 != 10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin drive_step(1'b1); repeat (7) @(negedge clk); end
    while ((cyc + 1 - rel) % 100 != 0) @(negedge clk);
    a_pclr = 1'b1; m_pos = 0;
    @(negedge clk); a_pclr = 1'b0;
    vectors++; if (a_pos !== 16'd0) begin miscompares++; $display("FAIL clrterm_pos got %0d exp 0", a_pos); end
    vectors++; if (a_vv !== 1'b1 || a_vel !== 8'sd3) begin miscompares++; $display("FAIL clrterm_vel got vv=%b vel=%0d exp vv=1 vel=3", a_vv, a_vel); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    bit f;
    for (int i = 0; i < 40; i++) begin
      f = ($urandom_range(0, 9) < 7);
      drive_step(f);
      repeat (6) @(negedge clk);
      vectors++; if (a_pos !== 16'(m_pos)) begin miscompares++; $display("FAIL rnd_pos i=%0d got %0d exp %0d", i, a_pos, m_pos); end
      vectors++; if (a_ec !== 32'(m_ec)) begin miscompares++; $display("FAIL rnd_ec i=%0d got %0d exp %0d", i, a_ec, m_ec); end
      vectors++; if (a_dir !== m_dir[0]) begin miscompares++; $display("FAIL rnd_dir i=%0d got %b exp %0d", i, a_dir, m_dir); end
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
  endtask

  task automatic test_rst_mid;
    while ((cyc - rel) % 100 != 15) @(negedge clk);
    for (int i = 0; i < 5; i++) begin drive_step(1'b1); repeat (3) @(negedge clk); end
    if (ph % 2 == 0) begin drive_step(1'b1); repeat (3) @(negedge clk); end
    while ((cyc - rel) % 100 != 49) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (a_pos !== 16'd0 || a_ec !== 32'd0 || a_vel !== 8'sd0 || a_vv !== 1'b0 || a_dir !== 1'b0 || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got pos=%0d ec=%0d vel=%0d vv=%b dir=%b err=%b exp all 0", a_pos, a_ec, a_vel, a_vv, a_dir, a_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset_release();
    repeat (8) @(negedge clk);
    vectors++; if (a_pos !== 16'd0 || a_ec !== 32'd0) begin miscompares++; $display("FAIL rstmid_nostep got pos=%0d ec=%0d exp 0 0", a_pos, a_ec); end
    for (int i = 0; i < 4; i++) begin drive_step(1'b1); repeat (9) @(negedge clk); end
    while (cyc < rel + 99) @(negedge clk);
    vectors++; if (a_vv !== 1'b0) begin miscompares++; $display("FAIL rstmid_vv_early got %b exp 0", a_vv); end
    @(negedge clk);
    vectors++; if (a_vv !== 1'b1 || a_vel !== 8'sd4) begin miscompares++; $display("FAIL rstmid_window got vv=%b vel=%0d exp vv=1 vel=4", a_vv, a_vel); end
  endtask

  task automatic test_saturate;
    int t;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset_release();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bph = (bph + 1) % 4;
      {b_a, b_b} = gray(bph);
    end
    t = 0;
    while (b_vv !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    vectors++;
    if (b_vv !== 1'b1) begin
      miscompares++; $display("FAIL sat_timeout got no vel_valid within 400 cycles");
    end else begin
      if (cyc !== rel + 256) begin miscompares++; $display("FAIL sat_when got cyc=%0d exp %0d", cyc, rel + 256); end
      vectors++; if (b_vel !== 8'sd127) begin miscompares++; $display("FAIL sat_vel got %0d exp 127", b_vel); end
      vectors++; if (b_ec !== 32'd200 || b_pos !== 16'd0 || b_dir !== 1'b1) begin
        miscompares++; $display("FAIL sat_counts got ec=%0d pos=%0d dir=%b exp 200 0 1", b_ec, b_pos, b_dir);
      end
      @(negedge clk);
      vectors++; if (b_vv !== 1'b0) begin miscompares++; $display("FAIL sat_pulse got %b exp 0", b_vv); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_err();
    test_clr_priority();
    test_clr_terminal();
    test_random();
    test_rst_mid();
    test_saturate();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
